// File: rtl/qtr_emu_pkg.sv
// Shared constants and channel state encoding for the QTR sensor emulator.
package qtr_emu_pkg;

    localparam int NCH_DEF        = 8;
    localparam int DW_DEF         = 16;
    localparam int MIN_CHARGE_DEF = 16;
    localparam logic [15:0] AMBIENT_DECAY_DEF = 16'd40000;

    typedef enum logic [1:0] {
        CH_IDLE     = 2'd0,
        CH_CHARGING = 2'd1,
        CH_CHARGED  = 2'd2,
        CH_DECAY    = 2'd3
    } ch_state_e;

endpackage

// File: rtl/qtr_sensor_emu_if.sv
// Controller-side pin bundle plus decay-table config port and per-channel state debug.
interface qtr_sensor_emu_if #(
    parameter int NCH = 8,
    parameter int DW  = 16
);
    // Pin semantics: while ch_oe[i] is 1 the controller owns line i and ch_level[i] follows
    // ch_dout[i]; once released the emulator holds the line for the programmed decay time.
    // cfg_we is a single-cycle strobe with no back-pressure.
    logic [NCH-1:0]   ch_oe;
    logic [NCH-1:0]   ch_dout;
    logic             led_even;
    logic             led_odd;
    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [DW-1:0]    cfg_data;
    logic [NCH-1:0]   ch_level;
    logic [NCH-1:0]   ch_busy;
    logic [NCH-1:0]   sample_done;
    logic [2*NCH-1:0] ch_state;

    modport master (
        output ch_oe, ch_dout, led_even, led_odd, cfg_we, cfg_addr, cfg_data,
        input  ch_level, ch_busy, sample_done, ch_state
    );

    modport slave (
        input  ch_oe, ch_dout, led_even, led_odd, cfg_we, cfg_addr, cfg_data,
        output ch_level, ch_busy, sample_done, ch_state
    );

endinterface

// File: rtl/qtr_emu_channel.sv
// One emulated sensor line: detects a full charge, then holds the line high for the
// latched decay time after the controller releases it.
module qtr_emu_channel
    import qtr_emu_pkg::*;
#(
    parameter int          DW            = DW_DEF,
    parameter int          MIN_CHARGE    = MIN_CHARGE_DEF,
    parameter logic [DW-1:0] AMBIENT_DECAY = DW'(AMBIENT_DECAY_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          oe,
    input  logic          dout,
    input  logic          led,
    input  logic [DW-1:0] decay_val,
    output logic          emu_level,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CHARGING = 2'd1;
    localparam logic [1:0] S_CHARGED  = 2'd2;
    localparam logic [1:0] S_DECAY    = 2'd3;

    localparam logic [DW-1:0] MIN_CNT = DW'(MIN_CHARGE);

    logic [DW-1:0] charge_cnt;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] lat;
    logic [DW-1:0] decay_sel;

    assign decay_sel = led ? decay_val : AMBIENT_DECAY;

    // The release cycle is decay cycle 0, so CHARGED already decides the line level
    // from the value that is about to be latched.
    always_comb begin
        emu_level = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            case (state)
                S_CHARGED: begin
                    busy      = 1'b1;
                    emu_level = oe ? 1'b1 : (decay_sel != '0);
                    done      = !oe && (decay_sel == '0);
                end
                S_DECAY: begin
                    busy      = 1'b1;
                    emu_level = (dcnt < lat);
                    done      = !oe && (dcnt >= lat);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            charge_cnt <= '0;
            dcnt       <= '0;
            lat        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (oe && dout) begin
                        charge_cnt <= DW'(1);
                        state      <= (MIN_CNT <= DW'(1)) ? S_CHARGED : S_CHARGING;
                    end
                end
                S_CHARGING: begin
                    if (!oe || !dout) begin
                        state      <= S_IDLE;
                        charge_cnt <= '0;
                    end else if (charge_cnt + DW'(1) >= MIN_CNT) begin
                        charge_cnt <= MIN_CNT;
                        state      <= S_CHARGED;
                    end else begin
                        charge_cnt <= charge_cnt + DW'(1);
                    end
                end
                S_CHARGED: begin
                    if (oe && !dout) begin
                        state      <= S_IDLE;
                        charge_cnt <= '0;
                    end else if (!oe) begin
                        charge_cnt <= '0;
                        lat        <= decay_sel;
                        dcnt       <= DW'(1);
                        state      <= (decay_sel == '0) ? S_IDLE : S_DECAY;
                    end
                end
                S_DECAY: begin
                    if (oe) begin
                        dcnt       <= '0;
                        charge_cnt <= dout ? DW'(1) : '0;
                        state      <= dout ? S_CHARGING : S_IDLE;
                    end else if (dcnt >= lat) begin
                        dcnt  <= '0;
                        state <= S_IDLE;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/qtr_sensor_emu.sv
// QTR reflectance-sensor emulator top: decay table, LED fan-out, per-channel FSMs and
// the controller-wins line mux.
module qtr_sensor_emu
    import qtr_emu_pkg::*;
#(
    parameter int            NCH           = NCH_DEF,
    parameter int            DW            = DW_DEF,
    parameter int            MIN_CHARGE    = MIN_CHARGE_DEF,
    parameter logic [DW-1:0] AMBIENT_DECAY = DW'(AMBIENT_DECAY_DEF)
) (
    input  logic             WF_CLK,
    input  logic             reset,
    qtr_sensor_emu_if.slave  bus
);

    logic [DW-1:0]  decay_tab [NCH];
    logic [NCH-1:0] emu_level;

    always_ff @(posedge WF_CLK) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                decay_tab[i] <= '0;
            end
        end else if (bus.cfg_we && (int'(bus.cfg_addr) < NCH)) begin
            decay_tab[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic led;
        assign led = ((g % 2) == 0) ? bus.led_even : bus.led_odd;

        qtr_emu_channel #(
            .DW            (DW),
            .MIN_CHARGE    (MIN_CHARGE),
            .AMBIENT_DECAY (AMBIENT_DECAY)
        ) u_ch (
            .clk       (WF_CLK),
            .rst       (reset),
            .oe        (bus.ch_oe[g]),
            .dout      (bus.ch_dout[g]),
            .led       (led),
            .decay_val (decay_tab[g]),
            .emu_level (emu_level[g]),
            .busy      (bus.ch_busy[g]),
            .done      (bus.sample_done[g]),
            .state     (bus.ch_state[2*g +: 2])
        );
    end

    assign bus.ch_level = (bus.ch_oe & bus.ch_dout) | (~bus.ch_oe & emu_level);

endmodule
